// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU breadboard types, widths and opcodes
package alu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;
  localparam int ALU_WIDTH = 16;
  localparam int PRODUCT_W = 32;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
endpackage

// File: rtl/twos_abs.sv
// twos_abs: sign flag and unsigned magnitude of a two's complement operand
module twos_abs #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  output logic             neg,
  output logic [WIDTH-1:0] mag
);
  // the most negative value negates to itself, which reads correctly as an unsigned magnitude
  always_comb begin
    neg = value[WIDTH-1];
    mag = neg ? -value : value;
  end
endmodule

// File: rtl/seq_multiply.sv
// seq_multiply: iterative signed shift-add multiplier with start/busy/done handshake
module seq_multiply
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [WIDTH-1:0]            multiplicand,
  input  logic [WIDTH-1:0]            multiplier,
  output logic                        busy,
  output logic                        done,
  output logic signed [PRODUCT_W-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t               state;
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     mag_a_r;
  logic [WIDTH-1:0]     mag_b_sr;
  logic                 neg_r;
  logic [PRODUCT_W-1:0] acc;
  logic                 neg_a;
  logic                 neg_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  twos_abs #(.WIDTH(WIDTH)) u_abs_a (.value(multiplicand), .neg(neg_a), .mag(mag_a));
  twos_abs #(.WIDTH(WIDTH)) u_abs_b (.value(multiplier), .neg(neg_b), .mag(mag_b));
  // control FSM with datapath: accept operands, one shift-add step per clock, then sign fix
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      mag_a_r  <= '0;
      mag_b_sr <= '0;
      neg_r    <= 1'b0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mag_a_r  <= mag_a;
          mag_b_sr <= mag_b;
          neg_r    <= neg_a ^ neg_b;
          acc      <= '0;
          count    <= '0;
          busy     <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          if (mag_b_sr[0]) acc <= acc + (PRODUCT_W'(mag_a_r) << count);
          mag_b_sr <= mag_b_sr >> 1;
          count    <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          product <= neg_r ? -acc : acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiply.sv
// tb_seq_multiply: directed self-checking bench for seq_multiply
module tb_seq_multiply;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] multiplicand = '0;
  logic signed [15:0] multiplier = '0;
  logic               busy;
  logic               done;
  logic signed [31:0] product;
  int                 checks = 0;
  int                 errors = 0;

  seq_multiply #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // wait up to limit edges for done; returns edges waited
  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [31:0] exp);
    int n;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(40, n);
    check({tag, " latency"}, 32'(n), 32'd17);
    check({tag, " product"}, product, exp);
    @(posedge clk); #1;
    check({tag, " done once"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    logic signed [31:0] prev;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("11x15", 16'sd11, 16'sd15, 32'sd165);
    run_op("32000x-16000", 16'sd32000, -16'sd16000, -32'sd512000000);
    run_op("min x min", 16'sh8000, 16'sh8000, 32'sd1073741824);
    run_op("0x-7", 16'sd0, -16'sd7, 32'sd0);
    run_op("-7x0", -16'sd7, 16'sd0, 32'sd0);
    run_op("-1x-1", -16'sd1, -16'sd1, 32'sd1);

    // start pulses and operand changes mid-op are ignored
    prev = product;
    @(negedge clk);
    multiplicand = 16'sd123;
    multiplier   = -16'sd45;
    start        = 1'b1;
    @(posedge clk); #1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      multiplicand = 16'sh7fff;
      multiplier   = -16'sd5;
      start        = (i == 3 || i == 10);
      @(posedge clk); #1;
      n++;
      if (i == 8) check("hold product mid-op", product, prev);
      if (i == 10) check("busy mid-op", 32'(busy), 32'd1);
      if (done) break;
    end
    start = 1'b0;
    check("ignore latency", 32'(n), 32'd17);
    check("ignore product", product, -32'sd5535);
    @(posedge clk); #1;
    check("ignore no second op", 32'(busy), 32'd0);

    // start held through the done cycle: second op accepted there
    @(negedge clk);
    multiplicand = 16'sd3;
    multiplier   = 16'sd4;
    start        = 1'b1;
    @(posedge clk); #1;
    multiplicand = -16'sd5;
    multiplier   = 16'sd6;
    wait_done(40, n);
    check("b2b first latency", 32'(n), 32'd17);
    check("b2b first product", product, 32'sd12);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check("b2b second busy", 32'(busy), 32'd1);
    begin
      int m;
      wait_done(40, m);
      n += m;
    end
    check("b2b done spacing", 32'(n), 32'd18);
    check("b2b second product", product, -32'sd30);

    // asynchronous reset mid-run aborts without a done pulse
    @(negedge clk);
    multiplicand = 16'sd100;
    multiplier   = 16'sd200;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("no done after abort", 32'(n), 32'd0);
    run_op("-7x9 after reset", -16'sd7, 16'sd9, -32'sd63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
